entity_scan_unit: RTL and testbench

//   Parametrised, pipelined successor to the frame builder's entity detector. It holds a

---
 rtl/frame_builder_pkg.sv | 31 +++
 rtl/entity_slot_match.sv | 22 ++
 rtl/entity_scan_unit.sv | 182 ++++++++++++++++++
 tb/tb_entity_scan_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_builder_pkg.sv
// Shared types and constants for the frame builder's entity scan path.
package frame_builder_pkg;

    localparam int ENT_ID_W       = 4;
    localparam int UPSCALE        = 5;
    localparam int TILE_PIX       = 8;
    localparam int TILE_LEN_PIXEL = TILE_PIX * UPSCALE;
    localparam int SCREEN_W       = 640;
    localparam int SCREEN_H       = 480;

    localparam logic [ENT_ID_W-1:0] ENTITY_NULL_ID = '1;

    typedef struct packed {
        logic [ENT_ID_W-1:0] id;
        logic [1:0]          orient;
        logic [7:0]          tile;      // [3:0] column, [7:4] row
    } entity_t;

    typedef struct packed {
        logic [2:0]          row;
        logic [ENT_ID_W-1:0] id;
        logic [1:0]          orient;
    } det_out_t;

    localparam entity_t ENTITY_EMPTY = '{id: ENTITY_NULL_ID, orient: 2'b00, tile: 8'h00};

    function automatic logic id_used(input logic [ENT_ID_W-1:0] id);
        return id != ENTITY_NULL_ID;
    endfunction

endpackage

// File: rtl/entity_slot_match.sv
// One entity slot: tile compare against the current pixel and sprite-row flip.
module entity_slot_match
    import frame_builder_pkg::*;
(
    input  entity_t    ent_i,
    input  logic       flip_i,
    input  logic       in_screen_i,
    input  logic [3:0] tile_x_i,
    input  logic [3:0] tile_y_i,
    input  logic [2:0] row_i,
    output logic       hit_o,
    output det_out_t   det_o
);

    always_comb begin
        hit_o = in_screen_i && id_used(ent_i.id)
                && (ent_i.tile[3:0] == tile_x_i)
                && (ent_i.tile[7:4] == tile_y_i);
        det_o = '{row: (flip_i ? ~row_i : row_i), id: ent_i.id, orient: ent_i.orient};
    end

endmodule

// File: rtl/entity_scan_unit.sv
// Double-buffered entity table with a two-stage per-pixel hit detector.
// Shadow writes become visible only when frame_start commits them to the active table.
module entity_scan_unit
    import frame_builder_pkg::*;
#(
    parameter int NUM_ENTITIES   = 9,
    parameter int ID_W           = ENT_ID_W,
    parameter int UPSCALE_FACTOR = UPSCALE,
    parameter int TILE_SIZE      = TILE_PIX,
    parameter int SCREEN_TILES_H = 16,
    parameter int SCREEN_TILES_V = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [$clog2(NUM_ENTITIES)-1:0] wr_index,
    input  logic [ID_W+9:0]                wr_entity,
    input  logic                           wr_flip,
    input  logic                           frame_start,
    input  logic                           pix_valid,
    input  logic [9:0]                     counter_H,
    input  logic [9:0]                     counter_V,
    output logic                           out_valid,
    output logic                           out_hit,
    output logic [ID_W+4:0]                out_entity,
    output logic [$clog2(NUM_ENTITIES)-1:0] out_index,
    output logic                           out_overlap
);

    localparam int IDX_W    = $clog2(NUM_ENTITIES);
    localparam int CNT_W    = $clog2(NUM_ENTITIES + 1);
    localparam int TILE_LEN = TILE_SIZE * UPSCALE_FACTOR;
    localparam int SCR_W    = SCREEN_TILES_H * TILE_LEN;
    localparam int SCR_H    = SCREEN_TILES_V * TILE_LEN;

    // ------------------------------------------------------------------
    // Entity tables
    // ------------------------------------------------------------------
    entity_t                 shadow_q [NUM_ENTITIES];
    entity_t                 shadow_d [NUM_ENTITIES];
    logic [NUM_ENTITIES-1:0] sh_flip_q;
    logic [NUM_ENTITIES-1:0] sh_flip_d;
    entity_t                 active_q [NUM_ENTITIES];
    logic [NUM_ENTITIES-1:0] act_flip_q;

    // The commit cycle owns the shadow table, so writes wait one cycle.
    assign wr_ready = ~frame_start;

    always_comb begin
        shadow_d  = shadow_q;
        sh_flip_d = sh_flip_q;
        if (wr_valid && wr_ready) begin
            for (int i = 0; i < NUM_ENTITIES; i++) begin
                if (wr_index == IDX_W'(i)) begin
                    shadow_d[i]  = entity_t'(wr_entity);
                    sh_flip_d[i] = wr_flip;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTITIES; i++) begin
                shadow_q[i] <= ENTITY_EMPTY;
                active_q[i] <= ENTITY_EMPTY;
            end
            sh_flip_q  <= '0;
            act_flip_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            sh_flip_q <= sh_flip_d;
            if (frame_start) begin
                active_q   <= shadow_q;
                act_flip_q <= sh_flip_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: pixel to tile coordinates and sprite row
    // ------------------------------------------------------------------
    logic       s1_valid_q,     s1_valid_d;
    logic       s1_in_screen_q, s1_in_screen_d;
    logic [3:0] s1_tile_x_q,    s1_tile_x_d;
    logic [3:0] s1_tile_y_q,    s1_tile_y_d;
    logic [2:0] s1_row_q,       s1_row_d;

    // Quotients only need 4 bits inside the visible area; in_screen masks the rest.
    always_comb begin
        s1_valid_d     = pix_valid;
        s1_in_screen_d = (counter_H < 10'(SCR_W)) && (counter_V < 10'(SCR_H));
        s1_tile_x_d    = 4'(counter_H / 10'(TILE_LEN));
        s1_tile_y_d    = 4'(counter_V / 10'(TILE_LEN));
        s1_row_d       = 3'((counter_V % 10'(TILE_LEN)) / 10'(UPSCALE_FACTOR));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q     <= 1'b0;
            s1_in_screen_q <= 1'b0;
            s1_tile_x_q    <= '0;
            s1_tile_y_q    <= '0;
            s1_row_q       <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_in_screen_q <= s1_in_screen_d;
            s1_tile_x_q    <= s1_tile_x_d;
            s1_tile_y_q    <= s1_tile_y_d;
            s1_row_q       <= s1_row_d;
        end
    end

    // ------------------------------------------------------------------
    // S2: per-slot match, priority select, overlap count
    // ------------------------------------------------------------------
    logic [NUM_ENTITIES-1:0] hit;
    det_out_t                det [NUM_ENTITIES];

    for (genvar g = 0; g < NUM_ENTITIES; g++) begin : g_slot
        entity_slot_match u_match (
            .ent_i       (active_q[g]),
            .flip_i      (act_flip_q[g]),
            .in_screen_i (s1_in_screen_q),
            .tile_x_i    (s1_tile_x_q),
            .tile_y_i    (s1_tile_y_q),
            .row_i       (s1_row_q),
            .hit_o       (hit[g]),
            .det_o       (det[g])
        );
    end

    logic             out_valid_q,   out_valid_d;
    logic             out_hit_q,     out_hit_d;
    det_out_t         out_entity_q,  out_entity_d;
    logic [IDX_W-1:0] out_index_q,   out_index_d;
    logic             out_overlap_q, out_overlap_d;
    logic [CNT_W-1:0] hit_cnt;

    // Walk from the top slot down so the lowest-index hit is the last one written.
    always_comb begin
        out_valid_d  = s1_valid_q;
        out_hit_d    = |hit;
        out_entity_d = '1;
        out_index_d  = '0;
        hit_cnt      = '0;
        for (int i = NUM_ENTITIES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                out_entity_d = det[i];
                out_index_d  = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_ENTITIES; i++) begin
            hit_cnt = hit_cnt + CNT_W'(hit[i]);
        end
        out_overlap_d = (hit_cnt >= CNT_W'(2));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_hit_q     <= 1'b0;
            out_entity_q  <= '1;
            out_index_q   <= '0;
            out_overlap_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_hit_q     <= out_hit_d;
            out_entity_q  <= out_entity_d;
            out_index_q   <= out_index_d;
            out_overlap_q <= out_overlap_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_hit     = out_hit_q;
    assign out_entity  = out_entity_q;
    assign out_index   = out_index_q;
    assign out_overlap = out_overlap_q;

endmodule

// File: tb/tb_entity_scan_unit.sv
// Bench for entity_scan_unit: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a table-level behavioural model.
module tb_entity_scan_unit;

    localparam int N = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_index = '0;
    logic [13:0] wr_entity = '0;
    logic        wr_flip = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  counter_H = '0;
    logic [9:0]  counter_V = '0;
    logic        out_valid;
    logic        out_hit;
    logic [8:0]  out_entity;
    logic [3:0]  out_index;
    logic        out_overlap;

    entity_scan_unit dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_index    (wr_index),
        .wr_entity   (wr_entity),
        .wr_flip     (wr_flip),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .counter_H   (counter_H),
        .counter_V   (counter_V),
        .out_valid   (out_valid),
        .out_hit     (out_hit),
        .out_entity  (out_entity),
        .out_index   (out_index),
        .out_overlap (out_overlap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: two tables of plain ints, pixel math by arithmetic
    // ------------------------------------------------------------------
    int act_id [N], act_or [N], act_tile [N], act_fl [N];
    int sh_id  [N], sh_or  [N], sh_tile  [N], sh_fl  [N];
    int m_pv = 0, m_h = 0, m_v = 0;
    int e_full = 1, e_valid = 0, e_hit = 0, e_ent = 'h1FF, e_idx = 0, e_ov = 0;

    function automatic void model_pixel(input int h, input int v,
                                        output int hit, output int ent,
                                        output int idx, output int ov);
        int tx, ty, row, cnt, r;
        bit ins;
        tx  = h / 40;
        ty  = v / 40;
        row = (v % 40) / 5;
        ins = (h < 640) && (v < 480);
        cnt = 0;
        hit = 0;
        ent = 'h1FF;
        idx = 0;
        for (int i = 0; i < N; i++) begin
            if (ins && act_id[i] != 15 && (act_tile[i] % 16) == tx && (act_tile[i] / 16) == ty) begin
                cnt++;
                if (hit == 0) begin
                    hit = 1;
                    idx = i;
                    r   = (act_fl[i] != 0) ? 7 - row : row;
                    ent = r * 64 + act_id[i] * 4 + act_or[i];
                end
            end
        end
        ov = (cnt >= 2) ? 1 : 0;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            act_id[i] = 15; act_or[i] = 0; act_tile[i] = 0; act_fl[i] = 0;
            sh_id[i]  = 15; sh_or[i]  = 0; sh_tile[i]  = 0; sh_fl[i]  = 0;
        end
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < N; i++) begin
                    act_id[i] = 15; act_or[i] = 0; act_tile[i] = 0; act_fl[i] = 0;
                    sh_id[i]  = 15; sh_or[i]  = 0; sh_tile[i]  = 0; sh_fl[i]  = 0;
                end
                m_pv = 0;
                e_full = 1; e_valid = 0; e_hit = 0; e_ent = 'h1FF; e_idx = 0; e_ov = 0;
            end else begin
                model_pixel(m_h, m_v, e_hit, e_ent, e_idx, e_ov);
                e_valid = m_pv;
                e_full  = m_pv;
                if (frame_start) begin
                    for (int i = 0; i < N; i++) begin
                        act_id[i] = sh_id[i]; act_or[i] = sh_or[i];
                        act_tile[i] = sh_tile[i]; act_fl[i] = sh_fl[i];
                    end
                end
                if (wr_valid && !frame_start && int'(wr_index) < N) begin
                    sh_id[wr_index]   = int'(wr_entity[13:10]);
                    sh_or[wr_index]   = int'(wr_entity[9:8]);
                    sh_tile[wr_index] = int'(wr_entity[7:0]);
                    sh_fl[wr_index]   = wr_flip ? 1 : 0;
                end
                m_pv = pix_valid ? 1 : 0;
                m_h  = int'(counter_H);
                m_v  = int'(counter_V);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_valid", out_valid, e_valid);
            if (e_full != 0) begin
                chk("model_hit", out_hit, e_hit);
                chk("model_entity", out_entity, e_ent);
                chk("model_index", out_index, e_idx);
                chk("model_overlap", out_overlap, e_ov);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (all start and end on a falling edge)
    // ------------------------------------------------------------------
    task automatic write_slot(input int idx, input int id, input int orient,
                              input int tile, input int flip);
        wr_valid  = 1'b1;
        wr_index  = 4'(idx);
        wr_entity = {4'(id), 2'(orient), 8'(tile)};
        wr_flip   = (flip != 0);
        @(negedge clk);
        wr_valid  = 1'b0;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic scan(input int h, input int v);
        pix_valid = 1'b1;
        counter_H = 10'(h);
        counter_V = 10'(v);
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input int hit, input int ent,
                              input int idx, input int ov);
        chk({name, "_valid"},   out_valid, 1);
        chk({name, "_hit"},     out_hit, hit);
        chk({name, "_entity"},  out_entity, ent);
        chk({name, "_index"},   out_index, idx);
        chk({name, "_overlap"}, out_overlap, ov);
    endtask

    task automatic expect_reset(input string name);
        chk({name, "_valid"},   out_valid, 0);
        chk({name, "_hit"},     out_hit, 0);
        chk({name, "_entity"},  out_entity, 'h1FF);
        chk({name, "_index"},   out_index, 0);
        chk({name, "_overlap"}, out_overlap, 0);
    endtask

    initial begin
        int id;
        repeat (3) @(negedge clk);
        expect_reset("reset");
        reset = 1'b0;
        #1 chk("wr_ready_after_reset", wr_ready, 1);
        @(negedge clk);

        // Commit then scan the covered tile
        write_slot(0, 3, 1, 'h21, 0);
        commit();
        scan(40, 80);
        expect_out("basic", 1, 'h00D, 0, 0);

        // Shadow write is invisible until committed
        write_slot(0, 5, 2, 'h33, 0);
        scan(120, 120);
        expect_out("shadow_hidden", 0, 'h1FF, 0, 0);
        commit();
        scan(120, 125);
        expect_out("shadow_commit", 1, 'h056, 0, 0);

        // Priority and overlap
        write_slot(0, 15, 0, 0, 0);
        write_slot(2, 7, 0, 'h00, 0);
        write_slot(5, 9, 3, 'h00, 0);
        commit();
        scan(0, 0);
        expect_out("priority", 1, 'h01C, 2, 1);

        // Vertical flip at both ends of the tile
        write_slot(2, 15, 0, 0, 0);
        write_slot(5, 15, 0, 0, 0);
        write_slot(8, 4, 1, 'h00, 1);
        commit();
        scan(0, 0);
        expect_out("flip_top", 1, 'h1D1, 8, 0);
        scan(0, 39);
        expect_out("flip_bottom", 1, 'h011, 8, 0);

        // Off-screen pixels and tile row 12 never hit
        write_slot(1, 6, 0, 'hC0, 0);
        commit();
        scan(650, 10);
        expect_out("off_right", 0, 'h1FF, 0, 0);
        scan(10, 490);
        expect_out("off_bottom", 0, 'h1FF, 0, 0);

        // Write held across the commit cycle lands after it
        wr_valid    = 1'b1;
        wr_index    = 4'd3;
        wr_entity   = {4'd2, 2'd0, 8'h77};
        wr_flip     = 1'b0;
        frame_start = 1'b1;
        #1 chk("wr_ready_commit", wr_ready, 0);
        @(negedge clk);
        frame_start = 1'b0;
        #1 chk("wr_ready_after_commit", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        scan(280, 280);
        expect_out("stalled_not_committed", 0, 'h1FF, 0, 0);
        commit();
        scan(280, 280);
        expect_out("stalled_committed", 1, 'h008, 3, 0);

        // Reset in the middle of a scan with a write pending
        pix_valid = 1'b1;
        counter_H = 10'd280;
        counter_V = 10'd280;
        @(negedge clk);
        counter_H = 10'd281;
        wr_valid  = 1'b1;
        wr_index  = 4'd0;
        wr_entity = {4'd1, 2'd0, 8'h77};
        reset     = 1'b1;
        @(negedge clk);
        expect_reset("mid_reset");
        reset     = 1'b0;
        wr_valid  = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        commit();
        scan(280, 280);
        expect_out("after_reset_empty", 0, 'h1FF, 0, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            wr_valid = ($urandom_range(9, 0) < 3);
            wr_index = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 9))
                                                    : 4'($urandom_range(8, 0));
            id = ($urandom_range(3, 0) == 0) ? 15 : int'($urandom_range(14, 0));
            if ($urandom_range(4, 0) != 0)
                wr_entity = {4'(id), 2'($urandom_range(3, 0)),
                             4'($urandom_range(3, 0)), 4'($urandom_range(4, 0))};
            else
                wr_entity = {4'(id), 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0))};
            wr_flip     = 1'($urandom_range(1, 0));
            frame_start = ($urandom_range(19, 0) == 0);
            pix_valid   = ($urandom_range(4, 0) != 0);
            if ($urandom_range(4, 0) != 0) begin
                counter_H = 10'($urandom_range(200, 0));
                counter_V = 10'($urandom_range(160, 0));
            end else begin
                counter_H = 10'($urandom_range(1023, 0));
                counter_V = 10'($urandom_range(1023, 0));
            end
            reset = ($urandom_range(499, 0) == 0);
            @(negedge clk);
        end
        reset       = 1'b0;
        wr_valid    = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
